mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port round-robin arbiter in front of a fixed-latency main memory.
// Port 0 is the instruction cache, port 1 the data cache. One access is in
// flight at a time and moves through IDLE -> BUSY -> DONE.
//
// Ports
//   clk              sole clock, rising edge
//   reset            asynchronous, active-low
//   req0/req1        access request per port
//   we0/we1          1 = write, 0 = read (held with req)
//   addr0/addr1      32-bit word address (held with req)
//   wdata0/wdata1    32-bit write data, [31:24] = byte lane 0
//   gnt0/gnt1        port owns memory (BUSY and DONE)
//   done0/done1      one-cycle completion pulse
//   rdata0/rdata1    registered read data, held until next read completion
//   mem_en           memory access strobe (BUSY)
//   mem_we           memory write enable, only while mem_en
//   mem_addr         latched address of the granted request
//   mem_wdata        latched write data of the granted request
//   mem_rdata        memory read data, valid on the last BUSY cycle
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter load value: BUSY lasts cnt+1 cycles, so loading LATENCY-1
    // gives exactly MEM_LATENCY cycles of mem_en.
    localparam logic [3:0] LOAD_CNT = 4'(MEM_LATENCY - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_cnt;
    logic        r_lastGrant;
    logic        r_owner;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic        w_anyReq;
    logic        w_winner;

    // Pick the winning port index. On a tie the port that was not granted
    // last goes first, so a lastGrant of 1 after reset favours port 0.
    always_comb begin
        w_anyReq = req0 | req1;
        w_winner = 1'b0;
        if (req0 && req1) begin
            w_winner = ~r_lastGrant;
        end else begin
            w_winner = req1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Requests only matter in IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyReq) w_nextState = BUSY;
            BUSY:    if (r_cnt == 4'd0) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Request latch, latency counter and read-data capture. The counter
    // stops at zero, and a reset anywhere in the access wipes everything
    // so no stale completion can leak out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= 4'd0;
            r_lastGrant <= 1'b1;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rdata0    <= 32'd0;
            r_rdata1    <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_owner     <= w_winner;
                        r_lastGrant <= w_winner;
                        r_we        <= w_winner ? we1 : we0;
                        r_addr      <= w_winner ? addr1 : addr0;
                        r_wdata     <= w_winner ? wdata1 : wdata0;
                        r_cnt       <= LOAD_CNT;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (!r_we) begin
                        if (r_owner) begin
                            r_rdata1 <= mem_rdata;
                        end else begin
                            r_rdata0 <= mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode from state and owner, so all of them are zero in
    // reset because the state is IDLE and the latches are cleared.
    always_comb begin
        gnt0      = (r_state != IDLE) && !r_owner;
        gnt1      = (r_state != IDLE) &&  r_owner;
        done0     = (r_state == DONE) && !r_owner;
        done1     = (r_state == DONE) &&  r_owner;
        mem_en    = (r_state == BUSY);
        mem_we    = (r_state == BUSY) && r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        rdata0    = r_rdata0;
        rdata1    = r_rdata1;
    end

endmodule
